seg7_bin2bcd_seq: RTL
=====================

Name: seg7_bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits directly upstream of the two-digit/multi-digit 7-segment drivers and turns a binary counter value into stable decimal digits plus a leading-zero blanking mask. It accepts one value per ready/valid handshake and holds its last result between conversions so the display never flickers.

Parameters:
W_BIN, 8, width of binary input.
N_DIGITS, 3, number of BCD output digits; elaboration error if 10**N_DIGITS < 2**W_BIN.

Ports:
clk  in  1  system clock (100 MHz domain)
rst_n  in  1  reset; asynchronous, active-low
in_valid  in  1  in_bin holds a value to convert
in_ready  out  1  block can accept a value; equals (state==IDLE) && rst_n
in_bin  in  W_BIN  binary value; sampled only on the acceptance edge
out_valid  out  1  one-cycle pulse: out_bcd/out_lz just updated
out_bcd  out  4*N_DIGITS  packed BCD, digit 0 (units) in [3:0]; held until the next completion
out_lz  out  N_DIGITS  bit i=1 if digit i and all higher digits are 0 (i>=1); bit 0 always 0

Behaviour:
- Reset (async assert, sync release): state=IDLE, out_bcd=0, out_valid=0, out_lz={N_DIGITS-1{1'b1}},1'b0, scratch regs=0, bit counter=0. in_ready=0 while rst_n=0.
- Reset mid-conversion aborts the conversion; no out_valid is produced. out_bcd reads 0.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. Acceptance edge = rising clk with in_valid&&in_ready. On it: bin shift reg<=in_bin, BCD scratch<=0, counter<=W_BIN, state<=SHIFT.
- SHIFT: each edge: every scratch nibble >=5 gets +3 (4-bit add, no carry out), then {scratch,bin} shifts left 1. Counter decrements.
- On the edge where the counter goes 1->0, the post-shift result is written directly to out_bcd, out_lz is computed from it, out_valid<=1, state<=DONE.
- Latency: out_valid is high during the cycle after the W_BIN-th edge following the acceptance edge (8 edges for the default).
- DONE: lasts exactly one cycle; out_valid=1, in_ready=0; next edge: out_valid<=0, state<=IDLE.
- Throughput: at most one acceptance per W_BIN+2 cycles. in_valid held high through busy time is accepted on the first IDLE edge.
- in_bin changes outside the acceptance edge are ignored. in_valid deasserting while busy has no effect.
- out_bcd and out_lz change only on the completion edge (or reset). They are glitch-free registered outputs.
- Every nibble of out_bcd is always in 0..9.
- Max input (2**W_BIN-1) converts without overflow, guaranteed by the parameter check.

Decomposition:
- Shared package/include seg7_pkg: state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2), BCD_W=4, ADD3_THRESH=4'd5.
- One sub-module: seg7_bcd_add3, a combinational 4-bit nibble corrector (in>=5 ? in+3 : in). It is instantiated N_DIGITS times by a generate loop.
- Leading-zero mask is a generate-loop OR-chain from the top digit down; it stays in the top module.

Test Plan:
- Reset, then in_bin=8'd255 with in_valid pulsed 1 cycle -> in_ready low next cycle. out_valid pulses 1 cycle, 8 edges after acceptance. out_bcd=12'h255, out_lz=3'b000.
- in_bin=8'd0 -> out_bcd=12'h000, out_lz=3'b110. in_bin=8'd9 -> 12'h009, out_lz=3'b110.
- in_bin=8'd10 -> 12'h010, out_lz=3'b100. in_bin=8'd100 -> 12'h100, out_lz=3'b000.
- in_valid held high continuously with in_bin stepping 0..255 each acceptance -> acceptances exactly 10 cycles apart. Every out_bcd matches the decimal of the accepted value. in_bin changes during SHIFT have no effect.
- Accept 8'd200, assert rst_n=0 asynchronously after 4 SHIFT edges (mid-cycle) -> out_bcd=0 and out_valid=0 immediately, in_ready=0 during reset. After release, in_ready=1. No out_valid appears for the aborted value. Then 8'd37 -> 12'h037.
- Exhaustive sweep, W_BIN=10, N_DIGITS=4, values 0..1023 -> all outputs match the reference model. Latency is 10 edges. Also elaborate with W_BIN=10, N_DIGITS=3 -> elaboration error.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared types and constants for the 7-segment BCD front end.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Converter control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of one BCD digit
    localparam int BCD_W = 4;

    // Nibbles at or above this value get +3 before the next shift
    localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;

endpackage
`default_nettype wire

// File: rtl/seg7_bcd_add3.sv
`default_nettype none
// ============================================================================
// Module      : seg7_bcd_add3
// Description : Combinational double-dabble nibble corrector (>=5 -> +3).
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_bcd_add3
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] i_nib,
    output logic [BCD_W-1:0] o_nib
);

    // Pre-correct so the following left shift carries cleanly into the next digit
    always_comb begin
        o_nib = (i_nib >= ADD3_THRESH) ? (i_nib + 4'd3) : i_nib;
    end

endmodule
`default_nettype wire

// File: rtl/seg7_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : seg7_bin2bcd_seq
// Description : Sequential binary-to-BCD converter (shift-and-add-3) with
//               ready/valid input, held BCD result and leading-zero mask.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int W_BIN    = 8,
    parameter int N_DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W_BIN-1:0]          in_bin,
    output logic                      out_valid,
    output logic [BCD_W*N_DIGITS-1:0] out_bcd,
    output logic [N_DIGITS-1:0]       out_lz
);

    localparam int                  c_SCR_W  = BCD_W * N_DIGITS;
    localparam int                  c_CNT_W  = $clog2(W_BIN + 1);
    // Units digit is never blanked; all higher digits blank on a zero value
    localparam logic [N_DIGITS-1:0] c_LZ_RST = {N_DIGITS{1'b1}} << 1;

    // Refuse to build a converter that cannot hold the largest input value
    if ((64'd10 ** N_DIGITS) < (64'd1 << W_BIN)) begin : g_size_check
        $error("seg7_bin2bcd_seq: N_DIGITS too small for W_BIN");
    end

    state_t               r_state_q,     w_state_d;
    logic [W_BIN-1:0]     r_bin_q,       w_bin_d;
    logic [c_SCR_W-1:0]   r_scr_q,       w_scr_d;
    logic [c_CNT_W-1:0]   r_cnt_q,       w_cnt_d;
    logic [c_SCR_W-1:0]   r_out_bcd_q,   w_out_bcd_d;
    logic [N_DIGITS-1:0]  r_out_lz_q,    w_out_lz_d;
    logic                 r_out_valid_q, w_out_valid_d;

    logic [c_SCR_W-1:0]   w_corr;
    logic [c_SCR_W-1:0]   w_scr_shift;
    logic [W_BIN-1:0]     w_bin_shift;
    logic [N_DIGITS-1:0]  w_lz;
    // The top corrected bit always shifts out as zero for a legal sizing
    logic                 w_unused_top;

    // One add-3 corrector per scratch digit
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_add3
        seg7_bcd_add3 u_add3 (
            .i_nib (r_scr_q[gi*BCD_W +: BCD_W]),
            .o_nib (w_corr[gi*BCD_W +: BCD_W])
        );
    end

    assign w_scr_shift  = {w_corr[c_SCR_W-2:0], r_bin_q[W_BIN-1]};
    assign w_bin_shift  = {r_bin_q[W_BIN-2:0], 1'b0};
    assign w_unused_top = w_corr[c_SCR_W-1];

    // Digit i blanks when it and every digit above it are zero
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lz
        if (gi == 0) begin : g_units
            assign w_lz[gi] = 1'b0;
        end else begin : g_upper
            assign w_lz[gi] = ~(|w_scr_shift[c_SCR_W-1 : gi*BCD_W]);
        end
    end

    assign in_ready  = (r_state_q == IDLE) && rst_n;
    assign out_valid = r_out_valid_q;
    assign out_bcd   = r_out_bcd_q;
    assign out_lz    = r_out_lz_q;

    // Next-state, datapath and result-register update
    always_comb begin
        w_state_d     = r_state_q;
        w_bin_d       = r_bin_q;
        w_scr_d       = r_scr_q;
        w_cnt_d       = r_cnt_q;
        w_out_bcd_d   = r_out_bcd_q;
        w_out_lz_d    = r_out_lz_q;
        w_out_valid_d = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (in_valid) begin
                    w_bin_d   = in_bin;
                    w_scr_d   = '0;
                    w_cnt_d   = c_CNT_W'(W_BIN);
                    w_state_d = SHIFT;
                end
            end
            SHIFT: begin
                w_scr_d = w_scr_shift;
                w_bin_d = w_bin_shift;
                w_cnt_d = r_cnt_q - c_CNT_W'(1);
                if (r_cnt_q == c_CNT_W'(1)) begin
                    w_out_bcd_d   = w_scr_shift;
                    w_out_lz_d    = w_lz;
                    w_out_valid_d = 1'b1;
                    w_state_d     = DONE;
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q     <= IDLE;
            r_bin_q       <= '0;
            r_scr_q       <= '0;
            r_cnt_q       <= '0;
            r_out_bcd_q   <= '0;
            r_out_lz_q    <= c_LZ_RST;
            r_out_valid_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_bin_q       <= w_bin_d;
            r_scr_q       <= w_scr_d;
            r_cnt_q       <= w_cnt_d;
            r_out_bcd_q   <= w_out_bcd_d;
            r_out_lz_q    <= w_out_lz_d;
            r_out_valid_q <= w_out_valid_d;
        end
    end

endmodule
`default_nettype wire
